// File: rtl/mul_sequencer.sv
// Iterative RV32M multiply unit: shift-add over ITERS cycles, stalls the pipe
// while running and presents one 32-bit write-back word in DONE.
module mul_sequencer #(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        kill,
   input  logic [1:0]  mul_op,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic        stall,
   output logic        busy,
   output logic        result_valid,
   output logic [31:0] result
);

   localparam int ITERS = 32 / BITS_PER_CYCLE;
   localparam int CW    = $clog2(ITERS);

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;

   generate
      if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 &&
          BITS_PER_CYCLE != 4 && BITS_PER_CYCLE != 8) begin : g_bad_bpc
         $error("mul_sequencer: BITS_PER_CYCLE must be 1, 2, 4 or 8");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [63:0]    mcand_q, mcand_d;
   logic [31:0]    mplier_q, mplier_d;
   logic [63:0]    acc_q, acc_d;
   logic           neg_q, neg_d;
   logic           op_hi_q, op_hi_d;
   logic           busy_q, busy_d;
   logic           valid_q, valid_d;
   logic [31:0]    result_q, result_d;

   logic           a_neg, b_neg;
   logic [31:0]    a_mag, b_mag;
   logic [63:0]    pp, acc_sum, prod;

   always_comb begin
      a_neg = ((mul_op == OP_MULH) || (mul_op == OP_MULHSU)) & rs1_data[31];
      b_neg = (mul_op == OP_MULH) & rs2_data[31];
      a_mag = a_neg ? (~rs1_data + 32'd1) : rs1_data;
      b_mag = b_neg ? (~rs2_data + 32'd1) : rs2_data;
   end

   // mcand_q is |a| pre-shifted by cnt*BITS_PER_CYCLE, so each slice of |b| is a plain AND-add.
   always_comb begin
      pp = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (mplier_q[i]) pp = pp + (mcand_q << i);
      end
      acc_sum = acc_q + pp;
      prod    = neg_q ? (~acc_sum + 64'd1) : acc_sum;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      op_hi_d  = op_hi_q;
      valid_d  = 1'b0;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (start && !kill) begin
               state_d  = S_ITER;
               cnt_d    = '0;
               mcand_d  = {32'd0, a_mag};
               mplier_d = b_mag;
               acc_d    = '0;
               neg_d    = a_neg ^ b_neg;
               op_hi_d  = (mul_op != OP_MUL);
            end
         end
         S_ITER: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(ITERS - 1)) begin
               state_d  = S_DONE;
               valid_d  = 1'b1;
               result_d = op_hi_q ? prod[63:32] : prod[31:0];
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // A flush wins over everything, including a result about to complete.
      if (kill) begin
         state_d  = S_IDLE;
         valid_d  = 1'b0;
         result_d = result_q;
      end
   end

   assign busy_d = (state_d == S_ITER);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         op_hi_q  <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         op_hi_q  <= op_hi_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         result_q <= result_d;
      end
   end

   assign stall        = start & ~valid_q & ~kill;
   assign busy         = busy_q;
   assign result_valid = valid_q;
   assign result       = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboarded bench for mul_sequencer: one instance at 1 bit/cycle, one at 4 bits/cycle.
module tb_mul_sequencer;

   localparam logic [1:0] MUL = 2'b00, MULH = 2'b01, MULHSU = 2'b10, MULHU = 2'b11;

   logic clk = 1'b0;
   logic reset, kill;
   logic start, start4;
   logic [1:0] mul_op, mul_op4;
   logic [31:0] rs1, rs2, rs1_4, rs2_4;
   logic stall, busy, result_valid, stall4, busy4, result_valid4;
   logic [31:0] result, result4;

   int checks = 0;
   int failures = 0;
   logic [31:0] q[$];
   logic [31:0] q4[$];

   always #5 clk = ~clk;

   mul_sequencer #(.BITS_PER_CYCLE(1)) dut (
      .clk(clk), .reset(reset), .start(start), .kill(kill), .mul_op(mul_op),
      .rs1_data(rs1), .rs2_data(rs2), .stall(stall), .busy(busy),
      .result_valid(result_valid), .result(result));

   mul_sequencer #(.BITS_PER_CYCLE(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .kill(kill), .mul_op(mul_op4),
      .rs1_data(rs1_4), .rs2_data(rs2_4), .stall(stall4), .busy(busy4),
      .result_valid(result_valid4), .result(result4));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitors: every result_valid must match the oldest expected word.
   always @(negedge clk) begin
      if (result_valid === 1'b1) begin
         if (q.size() == 0) chk("unexpected_valid", 1, 0);
         else chk("result", result, q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (result_valid4 === 1'b1) begin
         if (q4.size() == 0) chk("unexpected_valid4", 1, 0);
         else chk("result4", result4, q4.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic drive(input bit sel, input logic st, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      if (sel) begin start4 = st; mul_op4 = op; rs1_4 = a; rs2_4 = b; end
      else begin start = st; mul_op = op; rs1 = a; rs2 = b; end
   endtask

   // Single op on the 1-bit instance; entered and left at posedge+1.
   task automatic run_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string nm);
      int lat = -1;
      bit stall_ok = 1'b1;
      q.push_back(exp);
      drive(0, 1'b1, op, a, b);
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (result_valid) begin lat = c; break; end
         if (!stall) stall_ok = 1'b0;
         @(posedge clk); #1;
      end
      chk({nm, "_latency"}, lat, 33);
      chk({nm, "_stall_while_running"}, stall_ok, 1);
      chk({nm, "_stall_in_done"}, stall, 0);
      @(posedge clk); #1;
      drive(0, 1'b0, op, a, b);
   endtask

   // Two ops with start held throughout; second operands appear the cycle after DONE.
   task automatic b2b(input bit sel,
                      input logic [1:0] op1, input logic [31:0] a1, input logic [31:0] b1, input logic [31:0] e1,
                      input logic [1:0] op2, input logic [31:0] a2, input logic [31:0] b2, input logic [31:0] e2,
                      input int lat_exp, input int gap_exp, input string nm);
      int v1 = -1;
      int v2 = -1;
      int c = 0;
      if (sel) begin q4.push_back(e1); q4.push_back(e2); end
      else begin q.push_back(e1); q.push_back(e2); end
      drive(sel, 1'b1, op1, a1, b1);
      while (c < 200 && v2 < 0) begin
         @(negedge clk);
         if (sel ? result_valid4 : result_valid) begin
            if (v1 < 0) v1 = c; else v2 = c;
         end
         @(posedge clk); #1;
         if (c == v1) drive(sel, 1'b1, op2, a2, b2);
         c++;
      end
      drive(sel, 1'b0, op2, a2, b2);
      chk({nm, "_first_latency"}, v1, lat_exp);
      chk({nm, "_spacing"}, v2 - v1, gap_exp);
   endtask

   initial begin
      int vcount;
      reset = 1'b0; kill = 1'b0;
      drive(0, 1'b0, MUL, 0, 0);
      drive(1, 1'b0, MUL, 0, 0);
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_busy4", busy4, 0);
      chk("rst_stall4", stall4, 0);
      reset = 1'b1;
      @(posedge clk); #1;

      run_mul(MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7_m3");
      run_mul(MULH,   32'h80000000, 32'h80000000, 32'h40000000, "mulh_min_min");
      run_mul(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max");
      run_mul(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1");
      run_mul(MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul_m1_m1");

      // start together with kill in IDLE must not be accepted
      start = 1'b1; kill = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("start_kill_no_accept_busy", busy, 0);
      chk("start_kill_stall", stall, 0);
      @(posedge clk); #1;
      start = 1'b0; kill = 1'b0;

      b2b(0, MUL, 32'd3, 32'd5, 32'd15, MUL, 32'd100, 32'd200, 32'd20000, 33, 34, "b2b_bpc1");
      b2b(1, MUL, 32'h12345678, 32'h10, 32'h23456780, MULHU, 32'h12345678, 32'h10, 32'h1, 9, 10, "b2b_bpc4");

      // kill at ITER cycle 10
      drive(0, 1'b1, MUL, 32'd9, 32'd9);
      repeat (10) @(posedge clk);
      #1;
      start = 1'b0; kill = 1'b1;
      @(negedge clk);
      chk("kill_busy_before", busy, 1);
      @(posedge clk); #1;
      kill = 1'b0;
      @(negedge clk);
      chk("kill_busy_after", busy, 0);
      vcount = 0;
      repeat (40) begin @(negedge clk); if (result_valid) vcount++; end
      chk("kill_no_valid", vcount, 0);
      @(posedge clk); #1;
      run_mul(MUL, 32'd3, 32'd5, 32'd15, "mul_after_kill");

      // asynchronous reset mid-ITER, away from any clock edge
      drive(0, 1'b1, MUL, 32'h1234, 32'h5678);
      repeat (10) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("async_rst_busy", busy, 0);
      chk("async_rst_result", result, 0);
      chk("async_rst_valid", result_valid, 0);
      start = 1'b0;
      #2;
      reset = 1'b1;
      vcount = 0;
      repeat (40) begin @(negedge clk); if (result_valid) vcount++; end
      chk("post_rst_no_valid", vcount, 0);
      chk("post_rst_busy", busy, 0);

      @(negedge clk);
      chk("scoreboard_drained", q.size(), 0);
      chk("scoreboard4_drained", q4.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
